// File: rtl/multicycle_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer that shares one memory port between fetch and data.
// Latency: branch 3, ALU/jal/store 4, load 5 cycles. Each memory wait cycle adds one.
// Backpressure: mem_req is held until mem_ack. A request left unacknowledged for MEM_TIMEOUT cycles faults.
module multicycle_seq #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TMO_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       branch,
    input  logic [3:0] mem_read,
    input  logic [3:0] mem_write,
    input  logic       reg_write,
    input  logic       mem_to_reg,
    input  logic       pc4_to_reg,
    input  logic       alu_zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic [3:0] mem_be,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       mdr_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       busy,
    output logic       retire,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t             state_q;
    logic [TMO_W-1:0]   tmo_q;

    // Instruction class captured in DECODE. The decoder inputs are not trusted after that cycle.
    logic               br_q;
    logic [3:0]         rd_q;
    logic [3:0]         wr_q;
    logic               rw_q;
    logic               m2r_q;
    logic               p4_q;

    logic               is_load;
    logic               is_store;
    logic               tmo_hit;
    state_t             next_instr;

    assign is_load    = |rd_q;
    assign is_store   = |wr_q;
    // This is the cycle in which the counter would reach the limit. An ack in the same cycle still wins.
    assign tmo_hit    = !mem_ack && (tmo_q == TMO_W'(MEM_TIMEOUT - 1));
    // run is only consulted at an instruction boundary.
    assign next_instr = run ? S_FETCH : S_IDLE;

    // Sequencer state, timeout counter and latched instruction class.
    // The counter is cleared on every ack. Request states are therefore always entered with it at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            br_q    <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            rw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            p4_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        state_q <= S_DECODE;
                        tmo_q   <= '0;
                    end else if (tmo_hit) begin
                        state_q <= S_FAULT;
                    end else begin
                        tmo_q   <= tmo_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    br_q  <= branch;
                    rd_q  <= mem_read;
                    wr_q  <= mem_write;
                    rw_q  <= reg_write;
                    m2r_q <= mem_to_reg;
                    p4_q  <= pc4_to_reg;
                    if ((|mem_read) && (|mem_write)) state_q <= S_FAULT;
                    else                             state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_load || is_store) state_q <= S_MEM;
                    else if (br_q)           state_q <= next_instr;
                    else                     state_q <= S_WB;
                end
                S_MEM: begin
                    if (mem_ack) begin
                        tmo_q   <= '0;
                        state_q <= is_load ? S_WB : next_instr;
                    end else if (tmo_hit) begin
                        state_q <= S_FAULT;
                    end else begin
                        tmo_q   <= tmo_q + 1'b1;
                    end
                end
                S_WB:    state_q <= next_instr;
                S_FAULT: state_q <= S_FAULT;
                default: state_q <= S_FAULT;
            endcase
        end
    end

    // Output decode from the current state and the latched class. Asserting reset forces IDLE, so every output drops immediately.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_be       = 4'b0000;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        mdr_we       = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'b00;
        rf_we        = 1'b0;
        wb_sel       = 2'b00;
        retire       = 1'b0;
        busy         = (state_q != S_IDLE) && (state_q != S_FAULT);
        fault        = (state_q == S_FAULT);
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                mem_be  = 4'b1111;
                ir_we   = mem_ack;
            end
            S_EXEC: begin
                if (!is_load && !is_store && br_q) begin
                    pc_we  = 1'b1;
                    pc_src = alu_zero ? 2'b01 : 2'b00;
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_be       = rd_q | wr_q;
                mem_we       = is_store;
                mdr_we       = mem_ack & is_load;
                if (mem_ack && !is_load) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            S_WB: begin
                rf_we  = rw_q | p4_q;
                wb_sel = p4_q ? 2'b10 : (m2r_q ? 2'b01 : 2'b00);
                pc_we  = 1'b1;
                pc_src = p4_q ? 2'b10 : 2'b00;
                retire = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench for multicycle_seq. It uses directed and randomized instruction streams.
// The expected output trace is built for each instruction from its class, its wait counts and alu_zero.
// Decoder inputs, alu_zero and mem_ack carry random values on the cycles where the sequencer must ignore them.
module tb_multicycle_seq;

    typedef struct packed {
        logic       br;
        logic [3:0] rd;
        logic [3:0] wr;
        logic       rw;
        logic       m2r;
        logic       p4;
    } dec_t;

    typedef struct packed {
        logic       req;
        logic       we;
        logic [3:0] be;
        logic       sel;
        logic       ir;
        logic       mdr;
        logic       pcwe;
        logic [1:0] pcsrc;
        logic       rfwe;
        logic [1:0] wbsel;
        logic       busy;
        logic       ret;
        logic       flt;
    } out_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       branch;
    logic [3:0] mem_read;
    logic [3:0] mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc4_to_reg;
    logic       alu_zero;
    logic       mem_ack;
    logic       mem_req;
    logic       mem_we;
    logic [3:0] mem_be;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       mdr_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       busy;
    logic       retire;
    logic       fault;

    out_t obs;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   idle_m;

    multicycle_seq #(.MEM_TIMEOUT(4), .TMO_W(3)) dut (
        .clk(clk), .reset(reset), .run(run), .branch(branch),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .pc4_to_reg(pc4_to_reg), .alu_zero(alu_zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we),
        .pc_src(pc_src), .rf_we(rf_we), .wb_sel(wb_sel), .busy(busy),
        .retire(retire), .fault(fault)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_we, mem_be, mem_addr_sel, ir_we, mdr_we, pc_we,
                  pc_src, rf_we, wb_sel, busy, retire, fault};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic dec_t rand_dec();
        logic [31:0] r;
        r = $urandom;
        return r[13:0];
    endfunction

    function automatic out_t busy_only();
        out_t o;
        o      = '0;
        o.busy = 1'b1;
        return o;
    endfunction

    task automatic drive(input logic r, input logic ack, input logic z, input dec_t d);
        run        = r;
        mem_ack    = ack;
        alu_zero   = z;
        branch     = d.br;
        mem_read   = d.rd;
        mem_write  = d.wr;
        reg_write  = d.rw;
        mem_to_reg = d.m2r;
        pc4_to_reg = d.p4;
    endtask

    // The task is entered at posedge+1. It drives the inputs and samples mid-cycle, then returns at the next posedge+1.
    task automatic do_cycle(input logic r, input logic ack, input logic z, input dec_t d,
                            input out_t exp, input string tag);
        drive(r, ack, z, d);
        #4;
        check_val(tag, {14'd0, obs}, {14'd0, exp});
        @(posedge clk);
        #1;
    endtask

    // The final cycle of an instruction drives run_after. That value decides between the next FETCH and IDLE.
    task automatic exec_instr(input dec_t d, input int fw, input int mw, input logic z,
                              input logic run_after, input string name);
        out_t e;
        bit   ld;
        bit   st;
        ld = |d.rd;
        st = |d.wr;
        if (idle_m) begin
            if (rb()) do_cycle(1'b0, rb(), rb(), rand_dec(), '0, {name, "_idle_hold"});
            do_cycle(1'b1, rb(), rb(), rand_dec(), '0, {name, "_idle_go"});
        end
        e      = '0;
        e.req  = 1'b1;
        e.be   = 4'hF;
        e.busy = 1'b1;
        for (int i = 0; i < fw; i++) do_cycle(rb(), 1'b0, rb(), rand_dec(), e, {name, "_fetch_wait"});
        e.ir = 1'b1;
        do_cycle(rb(), 1'b1, rb(), rand_dec(), e, {name, "_fetch_ack"});
        do_cycle(rb(), rb(), rb(), d, busy_only(), {name, "_decode"});
        if (ld || st) begin
            do_cycle(rb(), rb(), rb(), rand_dec(), busy_only(), {name, "_exec"});
            e      = '0;
            e.req  = 1'b1;
            e.sel  = 1'b1;
            e.we   = st;
            e.be   = ld ? d.rd : d.wr;
            e.busy = 1'b1;
            for (int i = 0; i < mw; i++) do_cycle(rb(), 1'b0, rb(), rand_dec(), e, {name, "_mem_wait"});
            e.mdr = ld;
            if (!ld) begin
                e.pcwe = 1'b1;
                e.ret  = 1'b1;
            end
            do_cycle(ld ? rb() : run_after, 1'b1, rb(), rand_dec(), e, {name, "_mem_ack"});
        end else if (d.br) begin
            e       = busy_only();
            e.pcwe  = 1'b1;
            e.pcsrc = z ? 2'b01 : 2'b00;
            e.ret   = 1'b1;
            do_cycle(run_after, rb(), z, rand_dec(), e, {name, "_exec_br"});
        end else begin
            do_cycle(rb(), rb(), rb(), rand_dec(), busy_only(), {name, "_exec"});
        end
        if (ld || (!st && !d.br)) begin
            e       = busy_only();
            e.rfwe  = d.rw | d.p4;
            e.wbsel = d.p4 ? 2'b10 : (d.m2r ? 2'b01 : 2'b00);
            e.pcwe  = 1'b1;
            e.pcsrc = d.p4 ? 2'b10 : 2'b00;
            e.ret   = 1'b1;
            do_cycle(run_after, rb(), rb(), rand_dec(), e, {name, "_wb"});
        end
        idle_m = !run_after;
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        check_val(tag, {14'd0, obs}, 32'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        idle_m = 1'b1;
    endtask

    initial begin
        dec_t d;
        out_t e;
        int   k;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_outputs", {14'd0, obs}, 32'd0);
        reset  = 1'b0;
        idle_m = 1'b1;

        // Reset asserted mid-FETCH while a request is outstanding
        e      = '0;
        e.req  = 1'b1;
        e.be   = 4'hF;
        e.busy = 1'b1;
        do_cycle(1'b1, 1'b0, 1'b0, '0, '0, "rst_idle_go");
        do_cycle(1'b1, 1'b0, 1'b0, '0, e, "rst_fetch0");
        do_cycle(1'b1, 1'b0, 1'b0, '0, e, "rst_fetch1");
        drive(1'b1, 1'b0, 1'b0, '0);
        #2;
        check_val("pre_rst_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check_val("async_rst_req", {31'd0, mem_req}, 32'd0);
        check_val("async_rst_busy", {31'd0, busy}, 32'd0);
        check_val("async_rst_all", {14'd0, obs}, 32'd0);
        @(posedge clk);
        #1;
        check_val("rst_held_all", {14'd0, obs}, 32'd0);
        reset  = 1'b0;
        idle_m = 1'b1;

        // Directed instructions
        d = '0; d.rw = 1'b1;
        exec_instr(d, 0, 0, 1'b0, 1'b1, "alu");
        d = '0; d.rd = 4'hF; d.rw = 1'b1; d.m2r = 1'b1;
        exec_instr(d, 0, 3, 1'b0, 1'b1, "load_w3");
        d = '0; d.br = 1'b1;
        exec_instr(d, 0, 0, 1'b1, 1'b1, "beq_taken");
        exec_instr(d, 0, 0, 1'b0, 1'b1, "beq_not");
        d = '0; d.p4 = 1'b1; d.rw = 1'b1;
        exec_instr(d, 0, 0, 1'b0, 1'b1, "jal");
        d = '0; d.wr = 4'b0011;
        exec_instr(d, 0, 0, 1'b0, 1'b1, "store");
        d = '0;
        exec_instr(d, 1, 0, 1'b0, 1'b0, "nop_stop");
        d = '0; d.rw = 1'b1;
        exec_instr(d, 3, 0, 1'b0, 1'b1, "alu_fetch_limit");
        d = '0; d.wr = 4'b1111;
        exec_instr(d, 0, 3, 1'b0, 1'b0, "store_mem_limit");

        // Random instruction stream
        repeat (60) begin
            d = '0;
            k = int'($urandom % 6);
            case (k)
                0: begin d.rw = rb(); end
                1: begin d.rd = 4'($urandom_range(1, 15)); d.rw = 1'b1; d.m2r = 1'b1; end
                2: begin d.wr = 4'($urandom_range(1, 15)); end
                3: begin d.br = 1'b1; end
                4: begin d.p4 = 1'b1; d.rw = rb(); end
                default: ;
            endcase
            exec_instr(d, int'($urandom % 4), int'($urandom % 4), rb(),
                       ($urandom % 4) != 0, "rand");
        end

        // Fetch timeout: four unacknowledged request cycles, then a sticky fault
        if (idle_m) do_cycle(1'b1, rb(), rb(), rand_dec(), '0, "tmo_idle_go");
        e      = '0;
        e.req  = 1'b1;
        e.be   = 4'hF;
        e.busy = 1'b1;
        for (int i = 0; i < 4; i++) do_cycle(rb(), 1'b0, rb(), rand_dec(), e, "tmo_fetch");
        e     = '0;
        e.flt = 1'b1;
        for (int i = 0; i < 3; i++) do_cycle(rb(), rb(), rb(), rand_dec(), e, "tmo_fault");
        pulse_reset("tmo_rst_clear");

        // Illegal decode: a load and a store together
        e      = '0;
        e.req  = 1'b1;
        e.be   = 4'hF;
        e.busy = 1'b1;
        e.ir   = 1'b1;
        do_cycle(1'b1, rb(), rb(), rand_dec(), '0, "ill_idle_go");
        do_cycle(1'b1, 1'b1, rb(), rand_dec(), e, "ill_fetch_ack");
        d = '0; d.rd = 4'b0001; d.wr = 4'b0001;
        do_cycle(1'b1, rb(), rb(), d, busy_only(), "ill_decode");
        e     = '0;
        e.flt = 1'b1;
        for (int i = 0; i < 2; i++) do_cycle(rb(), rb(), rb(), rand_dec(), e, "ill_fault");
        pulse_reset("ill_rst_clear");

        d = '0; d.rw = 1'b1;
        exec_instr(d, 0, 0, 1'b0, 1'b0, "alu_after_fault");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
